// File: rtl/pe_idx_seq_pkg.sv
// Shared types for the PE index sequencer: addressing modes, pad_code bit
// positions and the sequencer state encoding.
package pe_idx_seq_pkg;

    typedef enum logic [1:0] {
        IDX_FWD    = 2'b00,
        IDX_TRANS  = 2'b01,
        IDX_LINEAR = 2'b10,
        IDX_ROT    = 2'b11
    } idx_mode_t;

    localparam int PAD_TOP   = 0;
    localparam int PAD_BOT   = 1;
    localparam int PAD_LEFT  = 2;
    localparam int PAD_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/pe_idx_ram.sv
// Simple dual-port index RAM; the registered read port holds its last value
// while rd_en_i is low, so it can double as a stall-able pipeline stage.
module pe_idx_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pe_idx_seq.sv
// PE index sequencer: replays the sparse {y, x} index list for a number of
// passes and streams mapped data-buffer addresses over valid/ready.
//
// state    | meaning
// ST_IDLE  | waiting for start, index RAM writable
// ST_RUN   | issuing index RAM reads as the output stage frees up
// ST_DRAIN | last read issued, waiting for the final handshake
// ST_DONE  | one-cycle done pulse, start accepted again
module pe_idx_seq
    import pe_idx_seq_pkg::*;
#(
    parameter int IDX_W     = 4,
    parameter int IDX_DEPTH = 256,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  idx_mode_t                    mode,
    input  logic [CNT_W-1:0]             idx_cnt,
    input  logic [CNT_W-1:0]             trip_cnt,
    input  logic                         is_new,
    input  logic [3:0]                   pad_code,
    input  logic                         cut_y,
    input  logic                         idx_wr_en,
    input  logic [$clog2(IDX_DEPTH)-1:0] idx_wr_addr,
    input  logic [2*IDX_W-1:0]           idx_wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         wr_drop,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*IDX_W-1:0]           out_addr,
    output logic                         out_pad,
    output logic                         out_last,
    output logic                         out_clr
);

    localparam int ADDR_W = 2 * IDX_W;
    localparam int ENT_W  = 2 * IDX_W;
    localparam int RAM_AW = $clog2(IDX_DEPTH);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] i_q, i_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] trip_q, trip_d;
    idx_mode_t        mode_q, mode_d;
    logic             new_q, new_d;
    logic [3:0]       pad_q, pad_d;
    logic             cut_q, cut_d;

    // Metadata travelling alongside the RAM read register (the output stage).
    logic             s_vld_q, s_vld_d;
    logic             s_last_q, s_last_d;
    logic             s_clr_q, s_clr_d;
    logic [CNT_W-1:0] s_i_q, s_i_d;

    logic             wr_drop_q;
    logic             rd_en;
    logic [ENT_W-1:0] ram_dout;
    logic [IDX_W-1:0] ent_y, ent_x;
    logic             y_max, y_zero, x_max, x_zero;
    logic             cut_hit, vld_w, stage_free, busy_w;
    logic [ADDR_W-1:0] map_addr;
    logic             pad_w;
    logic [CNT_W-1:0] idx_clamped;

    assign busy_w = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    pe_idx_ram #(
        .DW    (ENT_W),
        .DEPTH (IDX_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (idx_wr_en && !busy_w),
        .wr_addr_i (idx_wr_addr),
        .wr_data_i (idx_wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (RAM_AW'(i_q)),
        .rd_data_o (ram_dout)
    );

    assign ent_y  = ram_dout[ENT_W-1:IDX_W];
    assign ent_x  = ram_dout[IDX_W-1:0];
    assign y_max  = &ent_y;
    assign y_zero = ~|ent_y;
    assign x_max  = &ent_x;
    assign x_zero = ~|ent_x;

    // A cut row entry becomes a bubble unless it carries out_last.
    assign cut_hit    = s_vld_q && cut_q && y_max && !s_last_q;
    assign vld_w      = s_vld_q && !cut_hit;
    assign stage_free = !vld_w || out_ready;

    assign idx_clamped = (32'(idx_cnt) >= IDX_DEPTH) ? CNT_W'(IDX_DEPTH - 1) : idx_cnt;

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        pass_d   = pass_q;
        last_d   = last_q;
        trip_d   = trip_q;
        mode_d   = mode_q;
        new_d    = new_q;
        pad_d    = pad_q;
        cut_d    = cut_q;
        s_vld_d  = s_vld_q;
        s_last_d = s_last_q;
        s_clr_d  = s_clr_q;
        s_i_d    = s_i_q;
        rd_en    = 1'b0;

        if (stage_free) begin
            s_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
                if (start) begin
                    state_d = ST_RUN;
                    i_d     = '0;
                    pass_d  = '0;
                    last_d  = idx_clamped;
                    trip_d  = trip_cnt;
                    mode_d  = mode;
                    new_d   = is_new;
                    pad_d   = pad_code;
                    cut_d   = cut_y;
                end
            end
            ST_RUN: begin
                if (stage_free) begin
                    rd_en    = 1'b1;
                    s_vld_d  = 1'b1;
                    s_i_d    = i_q;
                    s_last_d = (i_q == last_q);
                    s_clr_d  = new_q && (pass_q == '0);
                    if (i_q == last_q) begin
                        i_d    = '0;
                        pass_d = pass_q + 1'b1;
                        if (pass_q == trip_q) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (vld_w && out_ready) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            pass_q    <= '0;
            last_q    <= '0;
            trip_q    <= '0;
            mode_q    <= IDX_FWD;
            new_q     <= 1'b0;
            pad_q     <= '0;
            cut_q     <= 1'b0;
            s_vld_q   <= 1'b0;
            s_last_q  <= 1'b0;
            s_clr_q   <= 1'b0;
            s_i_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            pass_q    <= pass_d;
            last_q    <= last_d;
            trip_q    <= trip_d;
            mode_q    <= mode_d;
            new_q     <= new_d;
            pad_q     <= pad_d;
            cut_q     <= cut_d;
            s_vld_q   <= s_vld_d;
            s_last_q  <= s_last_d;
            s_clr_q   <= s_clr_d;
            s_i_q     <= s_i_d;
            wr_drop_q <= idx_wr_en && busy_w;
        end
    end

    always_comb begin
        map_addr = ram_dout;
        case (mode_q)
            IDX_FWD:    map_addr = {ent_y, ent_x};
            IDX_TRANS:  map_addr = {ent_x, ent_y};
            IDX_ROT:    map_addr = {~ent_y, ~ent_x};
            IDX_LINEAR: map_addr = ADDR_W'(s_i_q);
            default:    map_addr = ram_dout;
        endcase
    end

    // Pad tests look at the raw coordinates; a kept cut-row last entry is forced to pad.
    assign pad_w = (pad_q[PAD_TOP]   && y_zero) ||
                   (pad_q[PAD_BOT]   && y_max)  ||
                   (pad_q[PAD_LEFT]  && x_zero) ||
                   (pad_q[PAD_RIGHT] && x_max)  ||
                   (cut_q && y_max && s_last_q);

    assign busy      = busy_w;
    assign done      = (state_q == ST_DONE);
    assign wr_drop   = wr_drop_q;
    assign out_valid = vld_w;
    assign out_addr  = vld_w ? map_addr : '0;
    assign out_pad   = vld_w && pad_w;
    assign out_last  = vld_w && s_last_q;
    assign out_clr   = vld_w && s_clr_q;

endmodule

// File: tb/tb_pe_idx_seq.sv
// Directed bench for pe_idx_seq: index table entry i = {16-i, i}, jobs are
// collected at the falling edge and compared against hand-derived values.
module tb_pe_idx_seq;
    import pe_idx_seq_pkg::*;

    logic       clk, rst, start, is_new, cut_y, idx_wr_en;
    idx_mode_t  mode;
    logic [7:0] idx_cnt, trip_cnt, idx_wr_addr, idx_wr_data;
    logic [3:0] pad_code;
    logic       busy, done, wr_drop, out_valid, out_ready;
    logic [7:0] out_addr;
    logic       out_pad, out_last, out_clr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q_addr[$];
    logic       q_pad[$], q_last[$], q_clr[$];
    int         done_cycle, first_valid, stall_errs, drop_cnt, drop_cyc, done_cnt;
    logic       busy_end;

    pe_idx_seq #(.IDX_W(4), .IDX_DEPTH(256), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .idx_cnt(idx_cnt),
        .trip_cnt(trip_cnt), .is_new(is_new), .pad_code(pad_code), .cut_y(cut_y),
        .idx_wr_en(idx_wr_en), .idx_wr_addr(idx_wr_addr), .idx_wr_data(idx_wr_data),
        .busy(busy), .done(done), .wr_drop(wr_drop), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_pad(out_pad),
        .out_last(out_last), .out_clr(out_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_addr(idx_mode_t m, int i);
        logic [3:0] y, x;
        y = 4'(16 - i);
        x = 4'(i);
        case (m)
            IDX_FWD:   return {y, x};
            IDX_TRANS: return {x, y};
            IDX_ROT:   return {~y, ~x};
            default:   return 8'(i);
        endcase
    endfunction

    task automatic write_entry(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        idx_wr_en = 1'b1; idx_wr_addr = a; idx_wr_data = d;
        @(negedge clk);
        idx_wr_en = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx_wr_en = 1'b1; idx_wr_addr = 8'(i); idx_wr_data = exp_addr(IDX_FWD, i);
        end
        @(negedge clk);
        idx_wr_en = 1'b0;
    endtask

    task automatic set_cfg(input idx_mode_t m, input int ic, input int tc, input logic nw,
                           input logic [3:0] pc, input logic cy);
        mode = m; idx_cnt = 8'(ic); trip_cnt = 8'(tc); is_new = nw; pad_code = pc; cut_y = cy;
    endtask

    // Runs one job; the start cycle is cycle 1. Optional pokes: start / write at a cycle.
    task automatic run_job(input int ready_pct, input int poke_start, input int poke_wr,
                           input logic [7:0] wa, input logic [7:0] wd, input int budget);
        int cyc, tail;
        logic hold_v, h_pad, h_last, h_clr;
        logic [7:0] h_addr;
        q_addr.delete(); q_pad.delete(); q_last.delete(); q_clr.delete();
        done_cycle = 0; first_valid = 0; stall_errs = 0; drop_cnt = 0; drop_cyc = 0; done_cnt = 0;
        hold_v = 1'b0; h_addr = '0; h_pad = 1'b0; h_last = 1'b0; h_clr = 1'b0;
        tail = -1;
        @(negedge clk);
        start = 1'b1;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        if (poke_wr == 1) begin
            idx_wr_en = 1'b1; idx_wr_addr = wa; idx_wr_data = wd;
        end
        cyc = 1;
        while (cyc < budget && tail != 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; idx_wr_en = 1'b0;
            if (tail > 0) tail--;
            if (done) begin
                done_cnt++;
                if (done_cycle == 0) begin done_cycle = cyc; tail = 3; end
            end
            if (wr_drop) begin drop_cnt++; drop_cyc = cyc; end
            if (out_valid && first_valid == 0) first_valid = cyc;
            if (hold_v && (!out_valid || out_addr !== h_addr || out_pad !== h_pad ||
                           out_last !== h_last || out_clr !== h_clr)) stall_errs++;
            if (cyc == poke_start) begin start = 1'b1; mode = IDX_ROT; end
            if (cyc == poke_wr) begin idx_wr_en = 1'b1; idx_wr_addr = wa; idx_wr_data = wd; end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid && out_ready) begin
                q_addr.push_back(out_addr); q_pad.push_back(out_pad);
                q_last.push_back(out_last); q_clr.push_back(out_clr);
            end
            hold_v = out_valid && !out_ready;
            h_addr = out_addr; h_pad = out_pad; h_last = out_last; h_clr = out_clr;
        end
        busy_end = busy;
        start = 1'b0; idx_wr_en = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, wr_drop} !== 3'b000) begin
            miscompares++; $display("FAIL reset_status: got %b expected 000", {busy, done, wr_drop});
        end
        vectors++;
        if ({out_valid, out_pad, out_last, out_clr} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_stream: got %b expected 0000", {out_valid, out_pad, out_last, out_clr});
        end
        vectors++;
        if (out_addr !== 8'h00) begin
            miscompares++; $display("FAIL reset_addr: got %h expected 00", out_addr);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fwd();
        set_cfg(IDX_FWD, 15, 3, 1'b1, 4'b0000, 1'b0);
        run_job(100, -1, -1, 8'h00, 8'h00, 400);
        vectors++;
        if (done_cycle !== 67) begin miscompares++; $display("FAIL fwd_done_cycle: got %0d expected 67", done_cycle); end
        vectors++;
        if (first_valid !== 3) begin miscompares++; $display("FAIL fwd_first_valid: got %0d expected 3", first_valid); end
        vectors++;
        if (q_addr.size() !== 64) begin miscompares++; $display("FAIL fwd_count: got %0d expected 64", q_addr.size()); end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL fwd_done_pulses: got %0d expected 1", done_cnt); end
        for (int k = 0; k < 64 && k < q_addr.size(); k++) begin
            vectors++;
            if ({q_addr[k], q_pad[k], q_last[k], q_clr[k]} !==
                {exp_addr(IDX_FWD, k % 16), 1'b0, (k % 16) == 15, k < 16}) begin
                miscompares++;
                $display("FAIL fwd_out[%0d]: got addr=%h pad=%b last=%b clr=%b expected addr=%h pad=0 last=%b clr=%b",
                         k, q_addr[k], q_pad[k], q_last[k], q_clr[k], exp_addr(IDX_FWD, k % 16), (k % 16) == 15, k < 16);
            end
        end
    endtask

    task automatic test_modes();
        idx_mode_t  ms[3]     = '{IDX_TRANS, IDX_ROT, IDX_LINEAR};
        int         spot_i[3] = '{1, 1, 5};
        logic [7:0] spot_v[3] = '{8'h1F, 8'h0E, 8'h05};
        for (int m = 0; m < 3; m++) begin
            set_cfg(ms[m], 15, 0, 1'b0, 4'b0000, 1'b0);
            run_job(100, -1, -1, 8'h00, 8'h00, 200);
            vectors++;
            if (q_addr.size() !== 16) begin miscompares++; $display("FAIL mode%0d_count: got %0d expected 16", m, q_addr.size()); end
            vectors++;
            if (q_addr[spot_i[m]] !== spot_v[m]) begin
                miscompares++; $display("FAIL mode%0d_spot: got %h expected %h", m, q_addr[spot_i[m]], spot_v[m]);
            end
            for (int k = 0; k < 16 && k < q_addr.size(); k++) begin
                vectors++;
                if ({q_addr[k], q_last[k], q_clr[k]} !== {exp_addr(ms[m], k), k == 15, 1'b0}) begin
                    miscompares++;
                    $display("FAIL mode%0d_out[%0d]: got addr=%h last=%b clr=%b expected addr=%h last=%b clr=0",
                             m, k, q_addr[k], q_last[k], q_clr[k], exp_addr(ms[m], k), k == 15);
                end
            end
        end
    endtask

    task automatic test_pad_cut();
        int k;
        set_cfg(IDX_FWD, 15, 1, 1'b1, 4'b0101, 1'b1);
        run_job(100, -1, -1, 8'h00, 8'h00, 300);
        vectors++;
        if (q_addr.size() !== 30) begin miscompares++; $display("FAIL cut_count: got %0d expected 30", q_addr.size()); end
        vectors++;
        if (done_cycle !== 35) begin miscompares++; $display("FAIL cut_done_cycle: got %0d expected 35", done_cycle); end
        k = 0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 1) continue;
                if (k < q_addr.size()) begin
                    vectors++;
                    if ({q_addr[k], q_pad[k], q_last[k], q_clr[k]} !== {exp_addr(IDX_FWD, i), i == 0, i == 15, p == 0}) begin
                        miscompares++;
                        $display("FAIL cut_out[%0d]: got addr=%h pad=%b last=%b clr=%b expected addr=%h pad=%b last=%b clr=%b",
                                 k, q_addr[k], q_pad[k], q_last[k], q_clr[k], exp_addr(IDX_FWD, i), i == 0, i == 15, p == 0);
                    end
                end
                k++;
            end
        end
        // Cut-row entry that is also the last entry must still be emitted, padded.
        set_cfg(IDX_FWD, 1, 0, 1'b0, 4'b0000, 1'b1);
        run_job(100, -1, -1, 8'h00, 8'h00, 100);
        vectors++;
        if (q_addr.size() !== 2) begin miscompares++; $display("FAIL cutlast_count: got %0d expected 2", q_addr.size()); end
        vectors++;
        if ({q_addr[0], q_pad[0], q_last[0]} !== {8'h00, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL cutlast_e0: got addr=%h pad=%b last=%b expected 00/0/0", q_addr[0], q_pad[0], q_last[0]);
        end
        vectors++;
        if ({q_addr[1], q_pad[1], q_last[1]} !== {8'hF1, 1'b1, 1'b1}) begin
            miscompares++; $display("FAIL cutlast_e1: got addr=%h pad=%b last=%b expected f1/1/1", q_addr[1], q_pad[1], q_last[1]);
        end
    endtask

    task automatic test_backpressure();
        set_cfg(IDX_FWD, 15, 3, 1'b1, 4'b0000, 1'b0);
        run_job(50, -1, -1, 8'h00, 8'h00, 2000);
        vectors++;
        if (q_addr.size() !== 64) begin miscompares++; $display("FAIL bp_count: got %0d expected 64", q_addr.size()); end
        vectors++;
        if (stall_errs !== 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_errs); end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
        for (int k = 0; k < 64 && k < q_addr.size(); k++) begin
            vectors++;
            if ({q_addr[k], q_last[k], q_clr[k]} !== {exp_addr(IDX_FWD, k % 16), (k % 16) == 15, k < 16}) begin
                miscompares++;
                $display("FAIL bp_out[%0d]: got addr=%h last=%b clr=%b expected addr=%h last=%b clr=%b",
                         k, q_addr[k], q_last[k], q_clr[k], exp_addr(IDX_FWD, k % 16), (k % 16) == 15, k < 16);
            end
        end
    endtask

    task automatic test_busy_ignore();
        set_cfg(IDX_FWD, 15, 0, 1'b0, 4'b0000, 1'b0);
        run_job(100, 5, 8, 8'h03, 8'hAA, 200);
        mode = IDX_FWD;
        vectors++;
        if (q_addr.size() !== 16) begin miscompares++; $display("FAIL busy_count: got %0d expected 16", q_addr.size()); end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL busy_done_pulses: got %0d expected 1", done_cnt); end
        vectors++;
        if (busy_end !== 1'b0) begin miscompares++; $display("FAIL busy_restart: got busy=%b expected 0", busy_end); end
        vectors++;
        if (drop_cnt !== 1 || drop_cyc !== 9) begin
            miscompares++; $display("FAIL wr_drop_pulse: got count=%0d cycle=%0d expected count=1 cycle=9", drop_cnt, drop_cyc);
        end
        for (int k = 0; k < 16 && k < q_addr.size(); k++) begin
            vectors++;
            if (q_addr[k] !== exp_addr(IDX_FWD, k)) begin
                miscompares++; $display("FAIL busy_out[%0d]: got %h expected %h", k, q_addr[k], exp_addr(IDX_FWD, k));
            end
        end
        run_job(100, -1, -1, 8'h00, 8'h00, 200);
        vectors++;
        if (q_addr[3] !== 8'hD3) begin miscompares++; $display("FAIL wr_drop_ram: got %h expected d3", q_addr[3]); end
    endtask

    task automatic test_wr_start();
        set_cfg(IDX_FWD, 15, 0, 1'b0, 4'b0000, 1'b0);
        run_job(100, -1, 1, 8'h02, 8'h5A, 200);
        vectors++;
        if (q_addr[2] !== 8'h5A) begin miscompares++; $display("FAIL wr_start_e2: got %h expected 5a", q_addr[2]); end
        vectors++;
        if (q_addr[3] !== 8'hD3) begin miscompares++; $display("FAIL wr_start_e3: got %h expected d3", q_addr[3]); end
        write_entry(8'h02, exp_addr(IDX_FWD, 2));
    endtask

    task automatic test_reset_mid();
        set_cfg(IDX_FWD, 15, 3, 1'b1, 4'b0000, 1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if ({busy, out_valid} !== 2'b11) begin miscompares++; $display("FAIL midrst_pre: got busy/valid=%b expected 11", {busy, out_valid}); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, wr_drop, out_valid, out_pad, out_last, out_clr, out_addr} !== 15'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h expected 0000",
                     {busy, done, wr_drop, out_valid, out_pad, out_last, out_clr, out_addr});
        end
        @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL midrst_hold: got busy/done=%b expected 00", {busy, done}); end
        rst = 1'b1;
        set_cfg(IDX_FWD, 15, 0, 1'b0, 4'b0000, 1'b0);
        run_job(100, -1, -1, 8'h00, 8'h00, 200);
        vectors++;
        if (q_addr.size() !== 16 || first_valid !== 3) begin
            miscompares++; $display("FAIL midrst_restart: got count=%0d first=%0d expected 16/3", q_addr.size(), first_valid);
        end
        for (int k = 0; k < 16 && k < q_addr.size(); k++) begin
            vectors++;
            if (q_addr[k] !== exp_addr(IDX_FWD, k)) begin
                miscompares++; $display("FAIL midrst_out[%0d]: got %h expected %h", k, q_addr[k], exp_addr(IDX_FWD, k));
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; idx_wr_en = 1'b0; idx_wr_addr = '0; idx_wr_data = '0;
        out_ready = 1'b1;
        set_cfg(IDX_FWD, 0, 0, 1'b0, 4'b0000, 1'b0);
        test_reset();
        load_table();
        test_fwd();
        test_modes();
        test_pad_cut();
        test_backpressure();
        test_busy_ignore();
        test_wr_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
